// File: rtl/regfile_if.sv
// Register-file port bundle: two ID read ports, WB write port, ID issue port, debug read port.
// Latency: n/a (signal bundle only).
// Backpressure: none; every qualifier is sampled on each clock edge.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] raddr1_i;
    logic [DATA_W-1:0] rdata1_o;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata2_o;
    logic              we_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              issue_we_i;
    logic [ADDR_W-1:0] issue_dest_i;
    logic              busy1_o;
    logic              busy2_o;
    logic              sb_err_o;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_data_o;

    // Pipeline side (ID/WB/debugger) drives indices and write data.
    modport master (
        output raddr1_i, raddr2_i, we_i, waddr_i, wdata_i,
        output issue_we_i, issue_dest_i, dbg_addr_i,
        input  rdata1_o, rdata2_o, busy1_o, busy2_o, sb_err_o, dbg_data_o
    );

    // Register file side.
    modport slave (
        input  raddr1_i, raddr2_i, we_i, waddr_i, wdata_i,
        input  issue_we_i, issue_dest_i, dbg_addr_i,
        output rdata1_o, rdata2_o, busy1_o, busy2_o, sb_err_o, dbg_data_o
    );
endinterface

// File: rtl/regfile.sv
// GPR file with per-register pending write-back scoreboard; optional write-through via REGFILE_BYPASS_EN.
// Latency: reads/busy combinational (0 cycles); writes and scoreboard updates land on the rising edge.
// Backpressure: none; we_i/issue_we_i are single-cycle qualifiers sampled every edge, overflow/underflow sets sticky sb_err_o.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic      clk,
    input  logic      resetn,
    regfile_if.slave  rf
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs    [DEPTH];
    logic [1:0]        cnt     [DEPTH];
    logic [1:0]        cnt_nxt [DEPTH];
    logic [DEPTH-1:0]  inc_vec;
    logic [DEPTH-1:0]  dec_vec;
    logic              err_set;
    logic              sb_err_q;

    // Architectural storage; index 0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.we_i && (rf.waddr_i != '0)) begin
            regs[rf.waddr_i] <= rf.wdata_i;
        end
    end

    // One-hot issue (increment) and write-back (decrement) requests; register 0 is never tracked.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (rf.issue_we_i) begin
            inc_vec[rf.issue_dest_i] = 1'b1;
        end
        if (rf.we_i) begin
            dec_vec[rf.waddr_i] = 1'b1;
        end
        inc_vec[0] = 1'b0;
        dec_vec[0] = 1'b0;
    end

    // Next pending counts: saturate at 3 on issue and at 0 on write-back, flagging either as an error.
    always_comb begin
        err_set = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_nxt[r] = cnt[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt[r] == 2'd3) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[r] = cnt[r] + 2'd1;
                end
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt[r] == 2'd0) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[r] = cnt[r] - 2'd1;
                end
            end
        end
    end

    // Scoreboard counters and the sticky error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= 2'd0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            sb_err_q <= sb_err_q | err_set;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_hit1;
    logic wr_hit2;

    // Operand reads with same-cycle write-through; a write-back retiring the last pending write clears busy early.
    always_comb begin
        wr_hit1 = resetn && rf.we_i && (rf.waddr_i != '0) && (rf.waddr_i == rf.raddr1_i);
        wr_hit2 = resetn && rf.we_i && (rf.waddr_i != '0) && (rf.waddr_i == rf.raddr2_i);
        rf.rdata1_o = (rf.raddr1_i == '0) ? '0 : regs[rf.raddr1_i];
        rf.rdata2_o = (rf.raddr2_i == '0) ? '0 : regs[rf.raddr2_i];
        if (wr_hit1) begin
            rf.rdata1_o = rf.wdata_i;
        end
        if (wr_hit2) begin
            rf.rdata2_o = rf.wdata_i;
        end
        rf.busy1_o = (cnt[rf.raddr1_i] != 2'd0) && !(wr_hit1 && (cnt[rf.raddr1_i] == 2'd1));
        rf.busy2_o = (cnt[rf.raddr2_i] != 2'd0) && !(wr_hit2 && (cnt[rf.raddr2_i] == 2'd1));
    end
`else
    // Operand reads from stored contents only; busy reflects the counters alone.
    always_comb begin
        rf.rdata1_o = (rf.raddr1_i == '0) ? '0 : regs[rf.raddr1_i];
        rf.rdata2_o = (rf.raddr2_i == '0) ? '0 : regs[rf.raddr2_i];
        rf.busy1_o  = (cnt[rf.raddr1_i] != 2'd0);
        rf.busy2_o  = (cnt[rf.raddr2_i] != 2'd0);
    end
`endif

    // Debug port always shows committed state, never the in-flight write.
    always_comb begin
        rf.dbg_data_o = (rf.dbg_addr_i == '0) ? '0 : regs[rf.dbg_addr_i];
        rf.sb_err_o   = sb_err_q;
    end
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed literal checks plus randomized traffic against a behavioural model.
// Latency: model compared every falling edge once reset has been applied.
// Backpressure: none.
module tb_regfile;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 1 << AW;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    always #5 clk = ~clk;

    regfile_if #(.DATA_W(DW), .ADDR_W(AW)) rf ();

    regfile #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .rf     (rf.slave)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: architectural values, pending counts as plain integers, sticky error.
    logic [DW-1:0] m_regs [N];
    int            m_cnt  [N];
    bit            m_err;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int delta(input int r);
        int d;
        d = 0;
        if (rf.issue_we_i && (int'(rf.issue_dest_i) == r)) d = d + 1;
        if (rf.we_i && (int'(rf.waddr_i) == r)) d = d - 1;
        return d;
    endfunction

    // Model state update at each edge, cleared immediately by reset.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                m_regs[i] <= '0;
                m_cnt[i]  <= 0;
            end
            m_err <= 1'b0;
        end else begin
            if (rf.we_i && (rf.waddr_i != '0)) m_regs[rf.waddr_i] <= rf.wdata_i;
            for (int r = 1; r < N; r++) begin
                if ((m_cnt[r] + delta(r) > 3) || (m_cnt[r] + delta(r) < 0)) m_err <= 1'b1;
                else m_cnt[r] <= m_cnt[r] + delta(r);
            end
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (resetn && rf.we_i && (rf.waddr_i == a)) return rf.wdata_i;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (resetn && rf.we_i && (rf.waddr_i == a) && (m_cnt[a] == 1)) return 1'b0;
`endif
        return m_cnt[a] != 0;
    endfunction

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_rdata1", rf.rdata1_o, exp_rd(rf.raddr1_i));
            check("cmp_rdata2", rf.rdata2_o, exp_rd(rf.raddr2_i));
            check("cmp_busy1",  DW'(rf.busy1_o), DW'(exp_busy(rf.raddr1_i)));
            check("cmp_busy2",  DW'(rf.busy2_o), DW'(exp_busy(rf.raddr2_i)));
            check("cmp_sb_err", DW'(rf.sb_err_o), DW'(m_err));
            check("cmp_dbg",    rf.dbg_data_o, (rf.dbg_addr_i == '0) ? '0 : m_regs[rf.dbg_addr_i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        rf.raddr1_i = '0; rf.raddr2_i = '0; rf.we_i = 1'b0; rf.waddr_i = '0; rf.wdata_i = '0;
        rf.issue_we_i = 1'b0; rf.issue_dest_i = '0; rf.dbg_addr_i = '0;
        #2 resetn = 1'b0;
        #1 chk_en = 1'b1;
        tick();
        resetn = 1'b1;

        // Reset state
        rf.raddr1_i = 5'd5; rf.dbg_addr_i = 5'd5;
        #3;
        check("reset_rdata1", rf.rdata1_o, 32'h0);
        check("reset_busy1",  DW'(rf.busy1_o), 32'h0);
        check("reset_sb_err", DW'(rf.sb_err_o), 32'h0);

        // Write r5, visible after the edge; no issue preceded it, so the error flag sets
        tick();
        rf.we_i = 1'b1; rf.waddr_i = 5'd5; rf.wdata_i = 32'h1234_5678;
        tick();
        rf.we_i = 1'b0;
        #3;
        check("w5_rdata1", rf.rdata1_o, 32'h1234_5678);
        check("w5_dbg",    rf.dbg_data_o, 32'h1234_5678);
        check("w5_sb_err", DW'(rf.sb_err_o), 32'h1);

        // Write r0 is discarded
        rf.we_i = 1'b1; rf.waddr_i = 5'd0; rf.wdata_i = 32'hFFFF_FFFF; rf.raddr1_i = 5'd0;
        tick();
        rf.we_i = 1'b0;
        #3;
        check("w0_rdata1", rf.rdata1_o, 32'h0);
        check("w0_busy1",  DW'(rf.busy1_o), 32'h0);

        // Issue r7 three times, then a 4th overflows
        do_reset();
        rf.raddr1_i = 5'd7; rf.issue_we_i = 1'b1; rf.issue_dest_i = 5'd7;
        repeat (3) tick();
        #3;
        check("r7x3_busy1",  DW'(rf.busy1_o), 32'h1);
        check("r7x3_sb_err", DW'(rf.sb_err_o), 32'h0);
        tick();
        rf.issue_we_i = 1'b0;
        #3;
        check("r7x4_busy1",  DW'(rf.busy1_o), 32'h1);
        check("r7x4_sb_err", DW'(rf.sb_err_o), 32'h1);
        for (int i = 0; i < 3; i++) begin
            rf.we_i = 1'b1; rf.waddr_i = 5'd7; rf.wdata_i = 32'h700 + i;
            tick();
        end
        rf.we_i = 1'b0;
        #3;
        check("r7wb_busy1",  DW'(rf.busy1_o), 32'h0);
        check("r7wb_rdata1", rf.rdata1_o, 32'h702);

        // Same-edge issue and write of r3 with one pending
        do_reset();
        rf.raddr2_i = 5'd3; rf.issue_we_i = 1'b1; rf.issue_dest_i = 5'd3;
        tick();
        rf.we_i = 1'b1; rf.waddr_i = 5'd3; rf.wdata_i = 32'h3333;
        tick();
        rf.issue_we_i = 1'b0; rf.we_i = 1'b0;
        #3;
        check("r3same_busy2",  DW'(rf.busy2_o), 32'h1);
        check("r3same_sb_err", DW'(rf.sb_err_o), 32'h0);
        rf.we_i = 1'b1;
        tick();
        rf.we_i = 1'b0;
        #3;
        check("r3wb_busy2",  DW'(rf.busy2_o), 32'h0);
        check("r3wb_sb_err", DW'(rf.sb_err_o), 32'h0);
        rf.we_i = 1'b1;
        tick();
        rf.we_i = 1'b0;
        #3;
        check("r3under_sb_err", DW'(rf.sb_err_o), 32'h1);

        // Same-cycle write and read of r9
        do_reset();
        rf.we_i = 1'b1; rf.waddr_i = 5'd9; rf.wdata_i = 32'h1111_1111; rf.raddr2_i = 5'd9;
        tick();
        rf.wdata_i = 32'hCAFE_F00D;
        #3;
`ifdef REGFILE_BYPASS_EN
        check("r9_sameclk", rf.rdata2_o, 32'hCAFE_F00D);
`else
        check("r9_sameclk", rf.rdata2_o, 32'h1111_1111);
`endif
        tick();
        rf.we_i = 1'b0;
        #3;
        check("r9_next", rf.rdata2_o, 32'hCAFE_F00D);

        // Asynchronous reset mid-cycle clears everything at once
        do_reset();
        rf.issue_we_i = 1'b1; rf.issue_dest_i = 5'd4;
        repeat (2) tick();
        rf.issue_we_i = 1'b0;
        rf.we_i = 1'b1; rf.waddr_i = 5'd4; rf.wdata_i = 32'h0000_ABCD;
        tick();
        rf.we_i = 1'b0; rf.raddr1_i = 5'd4; rf.raddr2_i = 5'd4; rf.dbg_addr_i = 5'd4;
        rf.waddr_i = 5'd7; rf.wdata_i = 32'h0;
        rf.we_i = 1'b1;
        tick();
        rf.we_i = 1'b0;
        #1;
        check("pre_arst_rdata1", rf.rdata1_o, 32'h0000_ABCD);
        check("pre_arst_busy1",  DW'(rf.busy1_o), 32'h1);
        #1 resetn = 1'b0;
        #1;
        check("arst_rdata1", rf.rdata1_o, 32'h0);
        check("arst_rdata2", rf.rdata2_o, 32'h0);
        check("arst_dbg",    rf.dbg_data_o, 32'h0);
        check("arst_busy1",  DW'(rf.busy1_o), 32'h0);
        check("arst_busy2",  DW'(rf.busy2_o), 32'h0);
        check("arst_sb_err", DW'(rf.sb_err_o), 32'h0);
        tick();
        resetn = 1'b1;

        // Randomized traffic over a small index range to force collisions
        for (int i = 0; i < 800; i++) begin
            rf.raddr1_i     = AW'($urandom_range(0, 7));
            rf.raddr2_i     = AW'($urandom_range(0, 7));
            rf.dbg_addr_i   = AW'($urandom_range(0, 7));
            rf.we_i         = ($urandom_range(0, 9) < 4);
            rf.waddr_i      = AW'($urandom_range(0, 7));
            rf.wdata_i      = DW'($urandom);
            rf.issue_we_i   = ($urandom_range(0, 9) < 4);
            rf.issue_dest_i = AW'($urandom_range(0, 7));
            if ((i % 200) == 199) begin
                rf.we_i = 1'b0; rf.issue_we_i = 1'b0;
                do_reset();
            end else begin
                tick();
            end
        end

        rf.we_i = 1'b0; rf.issue_we_i = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
